// File: rtl/serial_parity_pkg.sv
// Shared constants and types for the serial parity framer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_parity_pkg;

    // Default number of serial bits collected into one word.
    localparam int WIDTH_DEFAULT = 8;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Bits needed for a bit-position counter over a word of 'width' bits.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/xor_accum.sv
// Running parity accumulator: toggles on each enabled '1' bit; clr wins over en.
// Latency: result visible one clock after the enabled bit.
// Backpressure: none; the caller gates en with its own handshake.
//
// Ports: clk/rst_n clock and async active-low reset, en accumulate d this cycle,
//        clr force the accumulator to 0 next cycle, q current accumulated parity.
module xor_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q = acc_q;

endmodule

// File: rtl/serial_parity_framer.sv
// Collects WIDTH serial bits (LSB first) into a word and presents it with a parity bit.
// Latency: word is valid one clock after its last bit is accepted.
// Backpressure: in_ready drops while the output word is held and out_ready is low, or on clear.
//
// Ports: clk, rst_n (async active-low); clear aborts the partial word;
//        in_valid/in_ready/in_bit serial input handshake;
//        out_valid/out_ready/out_data/out_parity word output handshake.
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity
);

    localparam int             CW      = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic           ODD_BIT = (ODD != 0);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             par_q,   par_d;
    out_state_e       state_q, state_d;

    logic accept;
    logic last_bit;
    logic complete;
    logic acc_q;

    // A held word may be replaced in the same cycle it is consumed, so
    // out_ready reopens the input even while the output register is full.
    assign in_ready = !clear && ((state_q == ST_EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_bit = (count_q == LAST);
    assign complete = accept && last_bit;

    // Parity of the bits collected so far in the current word; restarted on
    // completion so the next word begins from zero.
    xor_accum u_parity (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (clear || complete),
        .d     (in_bit),
        .q     (acc_q)
    );

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        state_d = state_q;

        if (clear) begin
            count_d = '0;
        end else if (accept) begin
            shift_d[count_q] = in_bit;
            count_d          = last_bit ? '0 : count_q + CW'(1);
        end

        // Every position is rewritten during a word, so stale bits left by a
        // clear never leak into a completed word.
        if (complete) begin
            data_d = shift_d;
            par_d  = acc_q ^ in_bit ^ ODD_BIT;
        end

        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // Completion while full implies out_ready (input is gated),
                // so the new word simply takes the slot.
                if (!complete && out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            state_q <= ST_EMPTY;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            state_q <= state_d;
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = data_q;
    assign out_parity = par_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Testbench for serial_parity_framer: directed scenarios plus random traffic
// checked against a queue-based word model; an ODD=1 instance shares the inputs.
// Runs to completion with a single summary line.
module tb_serial_parity_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;

    logic       in_ready,   in_ready_o;
    logic       out_valid,  out_valid_o;
    logic [7:0] out_data,   out_data_o;
    logic       out_parity, out_parity_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic       cur[$];       // bits of the word being collected
    logic       exp_full = 1'b0;
    logic [7:0] exp_word = 8'h00;
    int         n_out = 0;
    int         cyc   = 0;
    int         vq[$];        // cycles on which out_valid was observed
    logic       pq[$];        // parity observed on those cycles

    always #5 clk = ~clk;

    serial_parity_framer #(.WIDTH(8), .ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity)
    );

    serial_parity_framer #(.WIDTH(8), .ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready_o),
        .in_bit     (in_bit),
        .out_valid  (out_valid_o),
        .out_ready  (out_ready),
        .out_data   (out_data_o),
        .out_parity (out_parity_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the
    // model, then check the output register after the edge.
    task automatic cycle(input logic c, input logic v, input logic b, input logic r);
        logic       rdy;
        logic       acc;
        logic       otr;
        logic       done;
        logic [7:0] w;
        int         par;
        clear     = c;
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        #1;
        rdy = !c && (!exp_full || r);
        chk("in_ready", in_ready, rdy);
        chk("in_ready_odd", in_ready_o, rdy);
        acc  = v && rdy;
        otr  = exp_full && r;
        done = 1'b0;
        w    = 8'h00;
        if (c) begin
            cur.delete();
        end else if (acc) begin
            cur.push_back(b);
            if (cur.size() == 8) begin
                for (int i = 0; i < 8; i++) w[i] = cur[i];
                cur.delete();
                done = 1'b1;
            end
        end
        if (otr) n_out++;
        if (done) begin
            exp_full = 1'b1;
            exp_word = w;
        end else if (otr) begin
            exp_full = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("out_valid", out_valid, exp_full);
        chk("out_valid_odd", out_valid_o, exp_full);
        if (exp_full) begin
            par = $countones(exp_word) % 2;
            chk("out_data", out_data, exp_word);
            chk("out_data_odd", out_data_o, exp_word);
            chk("out_parity", out_parity, par);
            chk("out_parity_odd", out_parity_o, 1 - par);
        end
        if (out_valid) begin
            vq.push_back(cyc);
            pq.push_back(out_parity);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, w[i], r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] w07;
        int         n0;
        w07       = 8'h07;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_parity", out_parity, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x8D streamed with out_ready high; valid one cycle after last bit.
        send_word(8'h8D, 1'b1);
        chk("w8d_valid", out_valid, 1);
        chk("w8d_data", out_data, 8'h8D);
        chk("w8d_parity", out_parity, 0);
        idle(2);

        // 0x07: parity 1 for even build, 0 for odd build.
        send_word(8'h07, 1'b1);
        chk("w07_data", out_data, 8'h07);
        chk("w07_parity_even", out_parity, 1);
        chk("w07_parity_odd", out_parity_o, 0);
        idle(2);

        // Backpressure: 0x8D held, 0x07 offered while stalled.
        send_word(8'h8D, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, w07[0], 1'b0);
        chk("stall_ready", in_ready, 0);
        chk("stall_data", out_data, 8'h8D);
        cycle(1'b0, 1'b1, w07[0], 1'b1);
        for (int i = 1; i < 8; i++) cycle(1'b0, 1'b1, w07[i], 1'b0);
        chk("after_stall_valid", out_valid, 1);
        chk("after_stall_data", out_data, 8'h07);
        idle(2);

        // Clear aborts a partial word; only the following word emerges.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        n0 = n_out;
        send_word(8'h01, 1'b1);
        chk("clr_valid", out_valid, 1);
        chk("clr_data", out_data, 8'h01);
        chk("clr_parity", out_parity, 1);
        idle(2);
        chk("clr_word_count", n_out - n0, 1);

        // Async reset after 5 accepted bits (output register loaded with 0x5A).
        send_word(8'h5A, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_parity", out_parity, 0);
        cur.delete();
        exp_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_parity", out_parity, 0);
        idle(2);

        // Back-to-back streaming: two words exactly 8 cycles apart.
        vq.delete();
        pq.delete();
        send_word(8'h3C, 1'b1);
        send_word(8'hC3, 1'b1);
        idle(2);
        chk("stream_count", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("stream_gap", vq[1] - vq[0], 8);
            chk("stream_par0", pq[0], 0);
            chk("stream_par1", pq[1], 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  1'($urandom), ($urandom_range(3) != 0));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_parity_framer.md
SERIAL_PARITY_FRAMER -- requirements
Module: serial_parity_framer

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial bits per word (2..32).
REQ-002 Parameter: ODD, default 0, parity sense (0 = even parity bit, 1 = odd parity bit).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: clear  input  1  synchronous abort of the partially collected word.
REQ-006 Port: in_valid  input  1  in_bit carries a valid serial bit.
REQ-007 Port: in_ready  output  1  framer accepts in_bit this cycle.
REQ-008 Port: in_bit  input  1  serial data, LSB of word first.
REQ-009 Port: out_valid  output  1  out_data/out_parity hold a complete word.
REQ-010 Port: out_ready  input  1  consumer takes the word this cycle.
REQ-011 Port: out_data  output  WIDTH  assembled word, first received bit at bit 0.
REQ-012 Port: out_parity  output  1  parity bit of out_data per ODD.

Function
REQ-013 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-014 in_ready SHALL equal !clear && (!out_valid || out_ready), combinational, no other dependency.
REQ-015 Each accepted bit SHALL be stored at index count of the shift/assembly register; count increments 0..WIDTH-1.
REQ-016 Running parity SHALL update as parity_acc XOR in_bit on every accepted bit.
REQ-017 Accepting the bit at count == WIDTH-1 SHALL complete the word: count wraps to 0, parity_acc to 0, word and final parity loaded into output register.
REQ-018 out_valid SHALL assert on the cycle after the completing bit is accepted (latency 1 clock from last bit).
REQ-019 out_parity SHALL equal XOR-reduction of out_data when ODD=0, its inverse when ODD=1.
REQ-020 Output register state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 EMPTY -> FULL on word completion; FULL -> EMPTY on output transfer without completion; FULL -> FULL with new word when output transfer and completion coincide.
REQ-022 While FULL and !out_ready, out_data and out_parity SHALL stay stable and no input bit SHALL be accepted.
REQ-023 Back-to-back words with out_ready held high SHALL stream with no idle cycle: one bit accepted every cycle in_valid=1.
REQ-024 clear=1 SHALL reset count and parity_acc to 0 next cycle, discard the in-flight bit (in_ready=0), and leave the output register and out_valid untouched.
REQ-025 Bits presented with in_valid=0 SHALL be ignored; count and parity_acc unchanged.

Reset
REQ-026 rst_n low SHALL immediately force out_valid=0, out_data=0, out_parity=0, count=0, parity_acc=0, independent of clk.
REQ-027 Reset asserted mid-word SHALL discard the partial word; first accepted bit after release is bit 0 of a new word.
REQ-028 After rst_n release in_ready SHALL be 1 (subject to clear) from the first clock.

Structure
REQ-029 Package serial_parity_pkg SHALL hold the WIDTH default constant, the EMPTY/FULL state enum typedef and a count-width function ($clog2(WIDTH)).
REQ-030 Sub-module xor_accum (1-bit toggle register with enable, clear, async active-low reset) SHALL implement parity_acc; everything else inline in serial_parity_framer.

Verification (WIDTH=8 unless stated)
REQ-031 Bits 1,0,1,1,0,0,0,1, out_ready=1 -> out_data=0x8D, out_parity=0, out_valid one cycle after last bit.
REQ-032 Bits 1,1,1,0,0,0,0,0 -> out_data=0x07, out_parity=1 (ODD=0) and 0 (ODD=1 build).
REQ-033 out_ready=0, word 0x8D then 8 bits of 0x07 offered -> in_ready=0 after 0x8D completes, out_data stays 0x8D; out_ready=1 one cycle -> 0x07 assembled and presented next.
REQ-034 3 bits of 1, then clear=1 with in_valid=1, then bits of 0x01 -> single output 0x01, out_parity=1; no word from aborted bits.
REQ-035 rst_n low after 5 accepted bits -> out_valid=0 asynchronously; after release bits of 0xA5 -> out_data=0xA5, out_parity=0.
REQ-036 16 consecutive bits (0x3C then 0xC3), in_valid and out_ready held 1 -> two outputs exactly 8 cycles apart, both parity 0, in_ready never drops.
